// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with valid bit, hold, branch flush, load-use bubble
// insertion and saturating bubble/flush performance counters.
module id_ex_hazard #(
  parameter int SIZE = 32,
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] PC_ID,
  input  logic [SIZE-1:0] imm_ID,
  input  logic [SIZE-1:0] read_data1_ID,
  input  logic [SIZE-1:0] read_data2_ID,
  input  logic [REGW-1:0] rs1_ID,
  input  logic [REGW-1:0] rs2_ID,
  input  logic [REGW-1:0] wrin_ID,
  input  logic            use_rs1_ID,
  input  logic            use_rs2_ID,
  input  logic [3:0]      ALUOp_ID,
  input  logic [3:0]      entrada_alu_control_ID,
  input  logic [1:0]      AuipcLui_ID,
  input  logic            Branch_ID,
  input  logic            MemRead_ID,
  input  logic            MemtoReg_ID,
  input  logic            MemWrite_ID,
  input  logic            RegWrite_ID,
  input  logic            ALUSrc_ID,
  input  logic            valid_ID,
  input  logic            FLUSH,
  input  logic            HOLD,
  input  logic            CNT_CLR,
  output logic [SIZE-1:0] PC_EX,
  output logic [SIZE-1:0] imm_EX,
  output logic [SIZE-1:0] read_data1_EX,
  output logic [SIZE-1:0] read_data2_EX,
  output logic [REGW-1:0] rs1_EX,
  output logic [REGW-1:0] rs2_EX,
  output logic [REGW-1:0] wrin_EX,
  output logic            use_rs1_EX,
  output logic            use_rs2_EX,
  output logic [3:0]      ALUOp_EX,
  output logic [3:0]      entrada_alu_control_EX,
  output logic [1:0]      AuipcLui_EX,
  output logic            Branch_EX,
  output logic            MemRead_EX,
  output logic            MemtoReg_EX,
  output logic            MemWrite_EX,
  output logic            RegWrite_EX,
  output logic            ALUSrc_EX,
  output logic            valid_EX,
  output logic            stall_IF_ID,
  output logic [CNTW-1:0] bubble_count,
  output logic [CNTW-1:0] flush_count
);

  localparam int W = 4*SIZE + 3*REGW + 2 + 4 + 4 + 2 + 7;

  // All EX fields live in one flat register so a bubble is simply a '0 load.
  logic [W-1:0] ex_q;
  logic [W-1:0] ex_d;
  logic         load_use;
  logic         bubble_inc;

  assign {PC_EX, imm_EX, read_data1_EX, read_data2_EX, rs1_EX, rs2_EX, wrin_EX,
          use_rs1_EX, use_rs2_EX, ALUOp_EX, entrada_alu_control_EX, AuipcLui_EX,
          Branch_EX, MemRead_EX, MemtoReg_EX, MemWrite_EX, RegWrite_EX, ALUSrc_EX,
          valid_EX} = ex_q;

  // Control bits are qualified by valid_ID so an invalid slot is a clean NOP.
  assign ex_d = {PC_ID, imm_ID, read_data1_ID, read_data2_ID, rs1_ID, rs2_ID, wrin_ID,
                 use_rs1_ID, use_rs2_ID, ALUOp_ID, entrada_alu_control_ID, AuipcLui_ID,
                 Branch_ID & valid_ID, MemRead_ID & valid_ID, MemtoReg_ID & valid_ID,
                 MemWrite_ID & valid_ID, RegWrite_ID & valid_ID, ALUSrc_ID & valid_ID,
                 valid_ID};

  always_comb begin
    load_use = valid_EX & MemRead_EX & RegWrite_EX & (wrin_EX != '0) & valid_ID &
               ((use_rs1_ID & (rs1_ID == wrin_EX)) | (use_rs2_ID & (rs2_ID == wrin_EX)));
  end

  assign stall_IF_ID = HOLD | (load_use & ~FLUSH);
  assign bubble_inc  = load_use & ~FLUSH & ~HOLD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         ex_q <= '0;
    else if (FLUSH)    ex_q <= '0;
    else if (HOLD)     ex_q <= ex_q;
    else if (load_use) ex_q <= '0;
    else               ex_q <= ex_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (CNT_CLR) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (FLUSH && flush_count != '1)      flush_count  <= flush_count + 1'b1;
      if (bubble_inc && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard.sv
// Randomised and directed bench for id_ex_hazard: a default instance and a
// CNTW=2 instance share stimulus and are checked against a behavioural model.
module tb_id_ex_hazard;

  typedef struct packed {
    logic [31:0] pc, imm, rd1, rd2;
    logic [4:0]  rs1, rs2, wrin;
    logic        use1, use2;
    logic [3:0]  aluop, aluctl;
    logic [1:0]  auipc;
    logic        br, mr, m2r, mw, rw, alusrc, valid;
  } ex_t;

  logic CLK = 1'b0;
  logic RESET, FLUSH, HOLD, CNT_CLR;
  ex_t  id;

  logic [31:0] pc_ex[2], imm_ex[2], rd1_ex[2], rd2_ex[2];
  logic [4:0]  rs1_ex[2], rs2_ex[2], wrin_ex[2];
  logic        u1_ex[2], u2_ex[2], br_ex[2], mr_ex[2], m2r_ex[2], mw_ex[2];
  logic        rw_ex[2], as_ex[2], v_ex[2], stall[2];
  logic [3:0]  aluop_ex[2], aluctl_ex[2];
  logic [1:0]  auipc_ex[2];
  logic [15:0] bc0, fc0;
  logic [1:0]  bc1, fc1;
  ex_t         act, act1;

  ex_t exp;
  int  bc, fc;
  int  passed = 0;
  int  total = 0;

  always #5 CLK = ~CLK;

  id_ex_hazard dut (
    .CLK(CLK), .RESET(RESET),
    .PC_ID(id.pc), .imm_ID(id.imm), .read_data1_ID(id.rd1), .read_data2_ID(id.rd2),
    .rs1_ID(id.rs1), .rs2_ID(id.rs2), .wrin_ID(id.wrin),
    .use_rs1_ID(id.use1), .use_rs2_ID(id.use2),
    .ALUOp_ID(id.aluop), .entrada_alu_control_ID(id.aluctl), .AuipcLui_ID(id.auipc),
    .Branch_ID(id.br), .MemRead_ID(id.mr), .MemtoReg_ID(id.m2r), .MemWrite_ID(id.mw),
    .RegWrite_ID(id.rw), .ALUSrc_ID(id.alusrc), .valid_ID(id.valid),
    .FLUSH(FLUSH), .HOLD(HOLD), .CNT_CLR(CNT_CLR),
    .PC_EX(pc_ex[0]), .imm_EX(imm_ex[0]), .read_data1_EX(rd1_ex[0]), .read_data2_EX(rd2_ex[0]),
    .rs1_EX(rs1_ex[0]), .rs2_EX(rs2_ex[0]), .wrin_EX(wrin_ex[0]),
    .use_rs1_EX(u1_ex[0]), .use_rs2_EX(u2_ex[0]),
    .ALUOp_EX(aluop_ex[0]), .entrada_alu_control_EX(aluctl_ex[0]), .AuipcLui_EX(auipc_ex[0]),
    .Branch_EX(br_ex[0]), .MemRead_EX(mr_ex[0]), .MemtoReg_EX(m2r_ex[0]), .MemWrite_EX(mw_ex[0]),
    .RegWrite_EX(rw_ex[0]), .ALUSrc_EX(as_ex[0]), .valid_EX(v_ex[0]),
    .stall_IF_ID(stall[0]), .bubble_count(bc0), .flush_count(fc0)
  );

  id_ex_hazard #(.CNTW(2)) dut_sat (
    .CLK(CLK), .RESET(RESET),
    .PC_ID(id.pc), .imm_ID(id.imm), .read_data1_ID(id.rd1), .read_data2_ID(id.rd2),
    .rs1_ID(id.rs1), .rs2_ID(id.rs2), .wrin_ID(id.wrin),
    .use_rs1_ID(id.use1), .use_rs2_ID(id.use2),
    .ALUOp_ID(id.aluop), .entrada_alu_control_ID(id.aluctl), .AuipcLui_ID(id.auipc),
    .Branch_ID(id.br), .MemRead_ID(id.mr), .MemtoReg_ID(id.m2r), .MemWrite_ID(id.mw),
    .RegWrite_ID(id.rw), .ALUSrc_ID(id.alusrc), .valid_ID(id.valid),
    .FLUSH(FLUSH), .HOLD(HOLD), .CNT_CLR(CNT_CLR),
    .PC_EX(pc_ex[1]), .imm_EX(imm_ex[1]), .read_data1_EX(rd1_ex[1]), .read_data2_EX(rd2_ex[1]),
    .rs1_EX(rs1_ex[1]), .rs2_EX(rs2_ex[1]), .wrin_EX(wrin_ex[1]),
    .use_rs1_EX(u1_ex[1]), .use_rs2_EX(u2_ex[1]),
    .ALUOp_EX(aluop_ex[1]), .entrada_alu_control_EX(aluctl_ex[1]), .AuipcLui_EX(auipc_ex[1]),
    .Branch_EX(br_ex[1]), .MemRead_EX(mr_ex[1]), .MemtoReg_EX(m2r_ex[1]), .MemWrite_EX(mw_ex[1]),
    .RegWrite_EX(rw_ex[1]), .ALUSrc_EX(as_ex[1]), .valid_EX(v_ex[1]),
    .stall_IF_ID(stall[1]), .bubble_count(bc1), .flush_count(fc1)
  );

  assign act  = {pc_ex[0], imm_ex[0], rd1_ex[0], rd2_ex[0], rs1_ex[0], rs2_ex[0], wrin_ex[0],
                 u1_ex[0], u2_ex[0], aluop_ex[0], aluctl_ex[0], auipc_ex[0], br_ex[0], mr_ex[0],
                 m2r_ex[0], mw_ex[0], rw_ex[0], as_ex[0], v_ex[0]};
  assign act1 = {pc_ex[1], imm_ex[1], rd1_ex[1], rd2_ex[1], rs1_ex[1], rs2_ex[1], wrin_ex[1],
                 u1_ex[1], u2_ex[1], aluop_ex[1], aluctl_ex[1], auipc_ex[1], br_ex[1], mr_ex[1],
                 m2r_ex[1], mw_ex[1], rw_ex[1], as_ex[1], v_ex[1]};

  // Hazard rule evaluated directly on the modelled EX contents and current ID inputs.
  function automatic bit m_lu();
    return exp.valid && exp.mr && exp.rw && exp.wrin != 0 && id.valid &&
           ((id.use1 && id.rs1 == exp.wrin) || (id.use2 && id.rs2 == exp.wrin));
  endfunction

  function automatic bit m_stall();
    return HOLD || (m_lu() && !FLUSH);
  endfunction

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic tick();
    bit lu;
    @(posedge CLK);
    if (!RESET) begin
      lu = m_lu();
      if (FLUSH) begin
        exp = '0;
        fc++;
      end else if (HOLD) begin
        exp = exp;
      end else if (lu) begin
        exp = '0;
        bc++;
      end else begin
        exp = id;
        exp.br = id.br & id.valid;   exp.mr = id.mr & id.valid;
        exp.m2r = id.m2r & id.valid; exp.mw = id.mw & id.valid;
        exp.rw = id.rw & id.valid;   exp.alusrc = id.alusrc & id.valid;
      end
      if (CNT_CLR) begin
        bc = 0;
        fc = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; FLUSH = 1'b0; HOLD = 1'b0; CNT_CLR = 1'b0;
    id = '0; exp = '0; bc = 0; fc = 0;
    #2 RESET = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] r);
    id = '0;
    id.pc = 32'h1FC; id.mr = 1'b1; id.rw = 1'b1; id.m2r = 1'b1;
    id.alusrc = 1'b1; id.wrin = r; id.valid = 1'b1;
  endtask

  task automatic set_dep(input logic [4:0] r);
    id = '0;
    id.pc = 32'h200; id.rs1 = r; id.use1 = 1'b1; id.rs2 = 5'd3;
    id.rw = 1'b1; id.wrin = 5'd9; id.aluop = 4'h2; id.valid = 1'b1;
  endtask

  task automatic rand_id();
    id.pc = $urandom; id.imm = $urandom; id.rd1 = $urandom; id.rd2 = $urandom;
    id.rs1 = 5'($urandom_range(0, 3)); id.rs2 = 5'($urandom_range(0, 3));
    id.wrin = 5'($urandom_range(0, 3));
    id.use1 = 1'($urandom); id.use2 = 1'($urandom);
    id.aluop = 4'($urandom); id.aluctl = 4'($urandom); id.auipc = 2'($urandom);
    id.br = 1'($urandom); id.mr = 1'($urandom); id.m2r = 1'($urandom);
    id.mw = 1'($urandom); id.rw = ($urandom_range(0, 3) != 0);
    id.alusrc = 1'($urandom); id.valid = ($urandom_range(0, 4) != 0);
  endtask

  task automatic test_reset();
    RESET = 1'b1; FLUSH = 1'b0; HOLD = 1'b0; CNT_CLR = 1'b0;
    id = '0; exp = '0; bc = 0; fc = 0;
    #2;
    total++; if (act !== '0) $display("FAIL reset_ex act=%h exp=0", act); else passed++;
    total++; if ({bc0, fc0, bc1, fc1} !== '0) $display("FAIL reset_cnt act=%h exp=0", {bc0, fc0, bc1, fc1}); else passed++;
    total++; if (stall[0] !== 1'b0) $display("FAIL reset_stall act=%b exp=0", stall[0]); else passed++;
    #1 RESET = 1'b0;
  endtask

  task automatic test_stream();
    id = '0; id.pc = 32'h100; id.imm = 32'h10; id.rw = 1'b1; id.valid = 1'b1;
    tick();
    total++; if (pc_ex[0] !== 32'h100 || imm_ex[0] !== 32'h10) $display("FAIL stream_data act=%h/%h exp=100/10", pc_ex[0], imm_ex[0]); else passed++;
    total++; if (rw_ex[0] !== 1'b1 || v_ex[0] !== 1'b1) $display("FAIL stream_ctl act=%b%b exp=11", rw_ex[0], v_ex[0]); else passed++;
    total++; if (act !== exp) $display("FAIL stream_ex act=%h exp=%h", act, exp); else passed++;
    total++; if (stall[0] !== 1'b0) $display("FAIL stream_stall act=%b exp=0", stall[0]); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lw(5'd5); tick();
    set_dep(5'd5); #1;
    total++; if (stall[0] !== 1'b1) $display("FAIL lu_stall_n act=%b exp=1", stall[0]); else passed++;
    tick();
    total++; if (act !== '0) $display("FAIL lu_bubble act=%h exp=0", act); else passed++;
    total++; if (bc0 !== 16'd1) $display("FAIL lu_bcount act=%0d exp=1", bc0); else passed++;
    total++; if (stall[0] !== 1'b0) $display("FAIL lu_stall_n1 act=%b exp=0", stall[0]); else passed++;
    tick();
    total++; if (pc_ex[0] !== 32'h200 || v_ex[0] !== 1'b1) $display("FAIL lu_dep_pc act=%h exp=200", pc_ex[0]); else passed++;
    total++; if (act !== exp) $display("FAIL lu_dep_ex act=%h exp=%h", act, exp); else passed++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_lw(5'd0); tick();
    set_dep(5'd0); #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL nohz_x0_stall act=%b exp=0", stall[0]); else passed++;
    tick();
    total++; if (bc0 !== 16'd0 || v_ex[0] !== 1'b1) $display("FAIL nohz_x0 bc=%0d v=%b exp=0/1", bc0, v_ex[0]); else passed++;
    set_lw(5'd6); tick();
    set_dep(5'd6); id.use1 = 1'b0; #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL nohz_use_stall act=%b exp=0", stall[0]); else passed++;
    tick();
    total++; if (bc0 !== 16'd0 || act !== exp) $display("FAIL nohz_use bc=%0d act=%h exp=%h", bc0, act, exp); else passed++;
  endtask

  task automatic test_flush_hold();
    do_reset();
    set_lw(5'd5); tick();
    set_dep(5'd5); FLUSH = 1'b1; HOLD = 1'b1; #1;
    total++; if (stall[0] !== 1'b1) $display("FAIL fh_stall act=%b exp=1", stall[0]); else passed++;
    tick();
    FLUSH = 1'b0; HOLD = 1'b0;
    total++; if (act !== '0) $display("FAIL fh_bubble act=%h exp=0", act); else passed++;
    total++; if (fc0 !== 16'd1 || bc0 !== 16'd0) $display("FAIL fh_cnt fc=%0d bc=%0d exp=1/0", fc0, bc0); else passed++;
  endtask

  task automatic test_hold();
    ex_t frozen;
    do_reset();
    rand_id(); id.valid = 1'b1; tick();
    frozen = act;
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); tick();
      total++; if (act !== frozen || act !== exp) $display("FAIL hold_frozen%0d act=%h exp=%h", i, act, exp); else passed++;
    end
    #3 RESET = 1'b1; exp = '0; bc = 0; fc = 0;
    #1;
    total++; if (act !== '0 || act1 !== '0) $display("FAIL hold_async_rst act=%h exp=0", act); else passed++;
    total++; if (stall[0] !== 1'b1) $display("FAIL hold_rst_stall act=%b exp=1", stall[0]); else passed++;
    #1 RESET = 1'b0; HOLD = 1'b0;
    rand_id(); tick();
    total++; if (act !== exp) $display("FAIL rst_first_load act=%h exp=%h", act, exp); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_lw(5'd7); tick();
      set_dep(5'd7); tick(); tick();
    end
    total++; if (bc1 !== 2'd3) $display("FAIL sat_bc2 act=%0d exp=3", bc1); else passed++;
    total++; if (bc0 !== 16'd5) $display("FAIL sat_bc16 act=%0d exp=5", bc0); else passed++;
    set_lw(5'd7); tick();
    set_dep(5'd7); CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
    total++; if (bc1 !== 2'd0 || bc0 !== 16'd0) $display("FAIL clr_wins bc2=%0d bc16=%0d exp=0/0", bc1, bc0); else passed++;
    total++; if (act !== '0) $display("FAIL clr_bubble act=%h exp=0", act); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      FLUSH = ($urandom_range(0, 7) == 0);
      HOLD = ($urandom_range(0, 5) == 0);
      CNT_CLR = ($urandom_range(0, 29) == 0);
      #1;
      total++; if (stall[0] !== m_stall() || stall[1] !== m_stall()) $display("FAIL rnd_stall%0d act=%b%b exp=%b", i, stall[0], stall[1], m_stall()); else passed++;
      tick();
      total++; if (act !== exp || act1 !== exp) $display("FAIL rnd_ex%0d act=%h exp=%h", i, act, exp); else passed++;
      total++;
      if (bc0 !== 16'(sat(bc, 16)) || fc0 !== 16'(sat(fc, 16)) || bc1 !== 2'(sat(bc, 2)) || fc1 !== 2'(sat(fc, 2)))
        $display("FAIL rnd_cnt%0d act=%0d/%0d/%0d/%0d exp=%0d/%0d", i, bc0, fc0, bc1, fc1, bc, fc);
      else passed++;
    end
    FLUSH = 1'b0; HOLD = 1'b0; CNT_CLR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_hazard();
    test_flush_hold();
    test_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
